// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: Moore FSM that sequences the datapath strobes
// for LW/SW/R-type/SPECIAL2 CLO-CLZ/BEQ/J/ADDI and flags undecodable opcodes.
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
  parameter int         ALUOP_W   = 6,
  parameter logic [5:0] FUNCT_CLO = 6'b100001,
  parameter logic [5:0] FUNCT_CLZ = 6'b100000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               regWrite,
  output logic               regDst,
  output logic               memToReg,
  output logic [1:0]         pcSource,
  output logic               illegal_op,
  output logic [3:0]         state
);

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_ADDI     = 6'b001000;

  localparam logic [ALUOP_W-1:0] AOP_RTYPE = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AOP_SPC2  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AOP_SUB   = ALUOP_W'(3);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_special2;
  logic   r_is_lw;
  logic   r_illegal;
  logic   w_illegal;

  // Only the LW/SW distinction and the SPECIAL2 flag survive past DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FETCH;
      r_special2 <= 1'b0;
      r_is_lw    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      if (r_state == S_DECODE) begin
        r_special2 <= (opcode == OP_SPECIAL2);
        r_is_lw    <= (opcode == OP_LW);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_illegal   = 1'b0;
    aluOp       = AOP_ADD;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    pcSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = mem_ready;
        pcWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE: w_next = S_EXECUTE;
          OP_SPECIAL2: begin
            if (funct == FUNCT_CLO || funct == FUNCT_CLZ) begin
              w_next = S_EXECUTE;
            end else begin
              w_next    = S_FETCH;
              w_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = r_is_lw ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = r_special2 ? AOP_SPC2 : AOP_RTYPE;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = AOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        w_next   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign illegal_op = r_illegal;
  assign state      = r_state;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main control unit, built as a Moore FSM.
- Decodes the instruction opcode and drives the datapath control strobes.
- Produces the 6-bit aluOp word consumed by the ALU control decoder:
  - 000000: R-type, pass funct through.
  - 000001: SPECIAL2 CLO/CLZ.
  - 000010: add.
  - 000011: subtract.
- Sits between the instruction register and the datapath, and handshakes with memory through mem_ready.

Parameters:
ALUOP_W, 6, width of aluOp; fixed at 6 to match the ALU control decoder.
FUNCT_CLO, 6'b100001, SPECIAL2 funct code for CLO.
FUNCT_CLZ, 6'b100000, SPECIAL2 funct code for CLZ.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
opcode  input  6  instr[31:26] from the instruction register; sampled only in DECODE.
funct  input  6  instr[5:0]; sampled only in DECODE.
mem_ready  input  1  memory completes the current access this cycle.
aluOp  output  6  ALU control selector (encoding above).
aluSrcA  output  1  0 = PC, 1 = register A.
aluSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
iorD  output  1  0 = PC address, 1 = ALUOut address.
memRead, memWrite, irWrite, pcWrite, pcWriteCond, regWrite  output  1 each  datapath strobes.
regDst  output  1  0 = rt, 1 = rd.
memToReg  output  1  0 = ALUOut, 1 = MDR.
pcSource  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
illegal_op  output  1  one-cycle pulse on an undecodable instruction.
state  output  4  current state encoding, for debug and verification.

Behaviour:
- All outputs are decoded from the state register only (Moore), except that irWrite and pcWrite in FETCH are additionally gated by mem_ready.
- Any output not listed for a state is 0, and aluOp defaults to 000010.
- Async reset (reset_n=0): state=FETCH, special2 flag=0, illegal_op=0.
  - Reset mid-instruction aborts that instruction with no further strobes.
  - Outputs take FETCH values immediately.
- States (encoding in brackets):
  - FETCH[0]: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=000010, pcSource=00, irWrite=pcWrite=mem_ready. Hold while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE[1]: aluSrcA=0, aluSrcB=11, aluOp=000010. Latch special2 = (opcode==011100). Next state by opcode:
    - 000000 -> EXECUTE.
    - 011100 with funct CLO or CLZ -> EXECUTE.
    - 100011 (LW) or 101011 (SW) -> MEM_ADDR.
    - 000100 (BEQ) -> BRANCH.
    - 000010 (J) -> JUMP.
    - 001000 (ADDI) -> ADDI_EXEC.
    - Anything else, including SPECIAL2 with any other funct: -> FETCH and set illegal_op=1 for exactly the next cycle.
  - MEM_ADDR[2]: aluSrcA=1, aluSrcB=10, aluOp=000010. Next is MEM_READ if the latched opcode is LW, otherwise MEM_WRITE. The opcode is latched in DECODE; the IR is not re-sampled.
  - MEM_READ[3]: memRead=1, iorD=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB[4]: regWrite=1, regDst=0, memToReg=1. Next is FETCH.
  - MEM_WRITE[5]: memWrite=1, iorD=1. Hold until mem_ready, then FETCH. memWrite stays high for every wait cycle.
  - EXECUTE[6]: aluSrcA=1, aluSrcB=00. aluOp=000001 if special2, else 000000. Next is R_WB.
  - R_WB[7]: regWrite=1, regDst=1, memToReg=0. Next is FETCH.
  - BRANCH[8]: aluSrcA=1, aluSrcB=00, aluOp=000011, pcWriteCond=1, pcSource=01. Next is FETCH.
  - JUMP[9]: pcWrite=1, pcSource=10. Next is FETCH.
  - ADDI_EXEC[10]: aluSrcA=1, aluSrcB=10, aluOp=000010. Next is ADDI_WB.
  - ADDI_WB[11]: regWrite=1, regDst=0, memToReg=0. Next is FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH on the next edge.
- Cycle counts with mem_ready always 1:
  - LW: 5 cycles.
  - SW, R-type, SPECIAL2, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
- Each mem_ready wait cycle adds exactly one cycle.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- regWrite, memWrite and pcWrite are never high in the same cycle.

Test Plan:
- Reset: hold reset_n=0 mid-MEM_WRITE -> state=0 and memWrite=0 with no clock edge; memRead=1; after release, FETCH waits for mem_ready.
- LW (opcode 100011) with mem_ready=1 -> states 0,1,2,3,4; aluOp=000010 in states 0/1/2; regWrite=1 and memToReg=1 only in state 4.
- R-type then SPECIAL2: opcode 000000 -> aluOp=000000 in EXECUTE; then opcode 011100 with funct 100001 -> aluOp=000001 in EXECUTE; regDst=1 in R_WB both times.
- BEQ (000100) -> state 8 with aluOp=000011, pcWriteCond=1, pcSource=01; back in FETCH next cycle.
- Memory wait: SW with mem_ready low for 3 cycles in MEM_WRITE -> memWrite high for 4 cycles; state moves to FETCH only after mem_ready=1.
- Illegal: opcode 111111, then 011100 with funct 000010 -> each returns DECODE->FETCH with illegal_op high for exactly one cycle and no regWrite or memWrite.
